// File: rtl/regdump_pkg.sv
// regdump_pkg: shared types and constants for the debug register-dump sequencer.
//   state_t           - sequencer states, one per byte slot plus IDLE/LOAD/DONE
//   IDX_TAG           - upper nibble of the per-register index byte
//   DEFAULT_SYNC_BYTE - frame start marker
//   drives_byte()     - true for states that present a byte on the stream
package regdump_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SYNC,
        LOAD,
        IDX,
        B0,
        B1,
        B2,
        B3,
        DONE
    } state_t;

    localparam logic [3:0] IDX_TAG           = 4'h5;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic drives_byte(input state_t s);
        return (s == SYNC) || (s == IDX) || (s == B0) || (s == B1) ||
               (s == B2) || (s == B3);
    endfunction

endpackage

// File: rtl/regdump_seq.sv
// regdump_seq: debug register-dump sequencer.
// On start, walks the register-file debug select from FIRST_REG to LAST_REG,
// captures each 32-bit value and streams a frame of bytes:
//   SYNC_BYTE, then per register {IDX_TAG, index}, value[7:0] .. value[31:24].
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   start         - dump request (only honoured in IDLE)
//   busy, done    - frame in progress / one-cycle completion pulse
//   db_reg        - debug register select to the register file
//   db_val        - selected register value (combinational from db_reg)
//   tx_data/tx_valid/tx_ready - byte stream, valid/ready handshake
module regdump_seq
    import regdump_pkg::*;
#(
    parameter logic [3:0] FIRST_REG = 4'd0,
    parameter logic [3:0] LAST_REG  = 4'd15,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [3:0]  db_reg,
    input  logic [31:0] db_val,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    state_t      state, state_nxt;
    logic [31:0] capture;
    logic [7:0]  byte_nxt;
    logic        accept;

    assign accept = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)  state_nxt = SYNC;
            SYNC:    if (accept) state_nxt = LOAD;
            LOAD:                state_nxt = IDX;
            IDX:     if (accept) state_nxt = B0;
            B0:      if (accept) state_nxt = B1;
            B1:      if (accept) state_nxt = B2;
            B2:      if (accept) state_nxt = B3;
            B3:      if (accept) state_nxt = (db_reg == LAST_REG) ? DONE : LOAD;
            DONE:                state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so the byte is chosen for the state being
    // entered. While stalled the same state is re-entered and, since capture
    // and db_reg only move outside byte states, the byte reloads unchanged.
    always_comb begin
        byte_nxt = tx_data;
        case (state_nxt)
            SYNC:    byte_nxt = SYNC_BYTE;
            IDX:     byte_nxt = {IDX_TAG, db_reg};
            B0:      byte_nxt = capture[7:0];
            B1:      byte_nxt = capture[15:8];
            B2:      byte_nxt = capture[23:16];
            B3:      byte_nxt = capture[31:24];
            default: byte_nxt = tx_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            db_reg   <= FIRST_REG;
            capture  <= 32'h0;
        end else begin
            tx_valid <= drives_byte(state_nxt);
            busy     <= drives_byte(state_nxt) || (state_nxt == LOAD);
            done     <= (state_nxt == DONE);
            if (drives_byte(state_nxt))
                tx_data <= byte_nxt;
            // Only snapshot point for each register; later writes are not seen.
            if (state == LOAD)
                capture <= db_val;
            // Advance the select on the edge entering LOAD for the next register.
            if (state == B3 && accept && db_reg != LAST_REG)
                db_reg <= db_reg + 4'd1;
            if (state_nxt == IDLE)
                db_reg <= FIRST_REG;
        end
    end

endmodule

// File: tb/tb_regdump_seq.sv
module tb_regdump_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, busy, done, tx_valid, tx_ready;
    logic [3:0]  db_reg;
    logic [31:0] db_val;
    logic [7:0]  tx_data;

    logic        start1, busy1, done1, tx_valid1;
    logic [3:0]  db_reg1;
    logic [31:0] db_val1;
    logic [7:0]  tx_data1;

    logic [31:0] rf     [16];
    logic [31:0] exp_rf [16];
    logic [7:0]  exp_q  [$];

    int n_assert = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;

    logic       stall_prev = 1'b0;
    logic [7:0] data_prev  = 8'h00;

    always #5 clk = ~clk;

    assign db_val  = rf[db_reg];
    assign db_val1 = (db_reg1 == 4'd3) ? 32'hDEAD_BEEF : {28'h0BAD000, db_reg1};

    regdump_seq u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .db_reg(db_reg), .db_val(db_val), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    regdump_seq #(.FIRST_REG(4'd3), .LAST_REG(4'd3)) u_one (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .db_reg(db_reg1), .db_val(db_val1), .tx_data(tx_data1),
        .tx_valid(tx_valid1), .tx_ready(1'b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] idx;
            idx = i[3:0];
            exp_q.push_back({4'h5, idx});
            exp_q.push_back(exp_rf[i][7:0]);
            exp_q.push_back(exp_rf[i][15:8]);
            exp_q.push_back(exp_rf[i][23:16]);
            exp_q.push_back(exp_rf[i][31:24]);
        end
    endtask

    task automatic start_frame();
        acc_cnt = 0;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Waits for the done pulse; optionally randomises tx_ready and pokes
    // start during the DONE cycle.
    task automatic wait_done(input string tag, input bit rnd, input bit poke);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (rnd) tx_ready = ($urandom_range(0, 99) < 40);
            step();
        end
        if (got && poke) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        tx_ready = 1'b1;
        chk(tag, {31'b0, got}, 32'd1);
        chk({tag, "_q_empty"}, exp_q.size(), 32'd0);
    endtask

    // Stream monitor: sampled mid-cycle, so valid&&ready here means the
    // byte is taken on the coming edge.
    always @(negedge clk) begin
        if (stall_prev) begin
            chk("hold_valid", {31'b0, tx_valid}, 32'd1);
            chk("hold_data", {24'b0, tx_data}, {24'b0, data_prev});
        end
        if (tx_valid && tx_ready && !reset) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL extra_byte: observed %0h expected none", tx_data);
            end
            if (exp_q.size() != 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("byte", {24'b0, tx_data}, {24'b0, e});
            end
            acc_cnt++;
        end
        stall_prev = tx_valid && !tx_ready && !reset;
        data_prev  = tx_data;
    end

    initial begin
        logic [7:0] exp1 [6];
        int  n;
        bit  got;

        exp1 = '{8'hA5, 8'h53, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 15; i++) rf[i] = 32'h1000_0000 + i;
        rf[15] = 32'h0000_0040;
        for (int i = 0; i < 16; i++) exp_rf[i] = rf[i];
        reset = 1'b1; start = 1'b0; start1 = 1'b0; tx_ready = 1'b1;
        step(); step();

        // reset state
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'h00);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_db_reg", {28'b0, db_reg}, 32'd0);
        reset = 1'b0;
        step();

        // full dump, ready held high: cycle-exact busy/done
        start_frame();
        for (int c = 1; c <= 99; c++) begin
            chk($sformatf("busy_c%0d", c), {31'b0, busy}, {31'b0, (c >= 1 && c <= 97)});
            chk($sformatf("done_c%0d", c), {31'b0, done}, {31'b0, (c == 98)});
            if (c == 99) chk("idle_db_reg", {28'b0, db_reg}, 32'd0);
            step();
        end
        chk("frame1_q_empty", exp_q.size(), 32'd0);
        chk("frame1_len", acc_cnt, 32'd81);

        // random backpressure
        tx_ready = 1'b0;
        start_frame();
        wait_done("rand_done", 1'b1, 1'b0);
        chk("rand_len", acc_cnt, 32'd81);
        step();

        // overwrite r2 after its capture, r5 before its capture
        exp_rf[5] = 32'h5555_AAAA;
        start_frame();
        for (int i = 0; i < 200 && acc_cnt < 13; i++) step();
        chk("reach_r2_b1", acc_cnt, 32'd13);
        tx_ready = 1'b0;
        rf[2] = 32'h2222_CCCC;
        rf[5] = 32'h5555_AAAA;
        step(); step(); step();
        tx_ready = 1'b1;
        wait_done("ovw_done", 1'b0, 1'b0);
        exp_rf[2] = rf[2];
        step();

        // start during busy and during DONE is dropped
        start_frame();
        step(); step(); step(); step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("ign_done", 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("ign_busy", {31'b0, busy}, 32'd0);
            chk("ign_valid", {31'b0, tx_valid}, 32'd0);
            step();
        end

        // reset at reg 7 B2
        start_frame();
        for (int i = 0; i < 200 && acc_cnt < 39; i++) step();
        chk("reach_r7_b2", acc_cnt, 32'd39);
        reset = 1'b1;
        tx_ready = 1'b0;
        step();
        reset = 1'b0;
        exp_q.delete();
        chk("mrst_valid", {31'b0, tx_valid}, 32'd0);
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_db_reg", {28'b0, db_reg}, 32'd0);
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("mrst_no_done", {31'b0, done}, 32'd0);
            step();
        end
        start_frame();
        wait_done("post_rst_done", 1'b0, 1'b0);
        chk("post_rst_len", acc_cnt, 32'd81);
        step();

        // single-register frame on the FIRST_REG = LAST_REG = 3 instance
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done1) begin
                got = 1'b1;
                break;
            end
            if (tx_valid1) begin
                if (n < 6) chk($sformatf("one_byte%0d", n), {24'b0, tx_data1}, {24'b0, exp1[n]});
                n++;
            end
            step();
        end
        chk("one_len", n, 32'd6);
        chk("one_done", {31'b0, got}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regdump_seq.md
# regdump_seq

Debug register-dump sequencer: the reading end of the register file's debug port. On a start pulse it steps the 4-bit debug register select through a configurable range, captures each 32-bit value and streams it out as bytes over a valid/ready byte interface. The byte stream feeds a UART transmitter or trace FIFO for board-level inspection of processor state.

## Interface
- FIRST_REG, 0: first register index dumped (0..15)
- LAST_REG, 15: last register index dumped; must satisfy LAST_REG >= FIRST_REG
- SYNC_BYTE, 8'hA5: frame start byte sent once per dump

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  dump request, sampled in IDLE only
- busy  out  1  high from the cycle after start is accepted until the last byte is accepted
- done  out  1  one-cycle pulse after the last byte is accepted
- db_reg  out  4  debug register select to the register file
- db_val  in  32  debug register value, combinational from db_reg
- tx_data  out  8  stream byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts byte

## Operation
- States: IDLE, SYNC, LOAD, IDX, B0, B1, B2, B3, DONE.
- IDLE: db_reg = FIRST_REG, tx_valid = 0. start = 1 moves to SYNC.
- SYNC: tx_data = SYNC_BYTE, tx_valid = 1. On accept, go to LOAD.
- LOAD: tx_valid = 0. db_reg is stable. Latch db_val into a 32-bit capture register. Go to IDX.
- IDX: tx_data = {4'h5, db_reg}.
- B0..B3: tx_data = capture[7:0], [15:8], [23:16], [31:24], in that order (little-endian).
- Each byte state advances only on accept (tx_valid && tx_ready).
- On B3 accept:
  - If db_reg == LAST_REG, go to DONE.
  - Otherwise increment db_reg and go to LOAD.
- DONE: done = 1 for one cycle, busy = 0, then IDLE. db_reg returns to FIRST_REG on entry to IDLE.
- Each register is captured once, in its LOAD cycle. The dump is not an atomic snapshot across registers: a register written after its own LOAD cycle is not reflected in the dump.
- start while busy or in DONE is ignored and not queued.
- Frame length: 1 + 5*(LAST_REG-FIRST_REG+1) bytes.

## Timing
- Reset values: tx_valid = 0, tx_data = 8'h00, busy = 0, done = 0, db_reg = FIRST_REG, state = IDLE, capture = 0.
- All outputs are registered. db_reg changes only on the clock edge that enters LOAD, or on entry to IDLE.
- Valid/ready rules:
  - Once tx_valid is asserted, tx_data is held stable until accepted.
  - tx_valid is never withdrawn before acceptance.
  - tx_ready may be asserted before tx_valid.
- Latency with tx_ready held high and start sampled at cycle 0:
  - SYNC byte valid at cycle 1.
  - Register k (k = 0 for FIRST_REG): LOAD at cycle 2+6k, bytes at cycles 3+6k..7+6k.
  - Full 16-register dump: last byte accepted at cycle 97, done at cycle 98, IDLE at cycle 99.
- tx_ready stalls stretch the current byte state only. Capture data is unaffected.
- reset mid-dump: next cycle is IDLE with tx_valid = 0. No done pulse, no partial-frame completion.
- FIRST_REG == LAST_REG: single-register frame of 6 bytes.

## Structure
- Package regdump_pkg:
  - state enum (9 states)
  - IDX_TAG constant 4'h5
  - default SYNC_BYTE
- Single module. The FSM, capture register and byte mux fit comfortably.
- No sub-module is required. Optionally factor the byte mux into regdump_bytesel (combinational select of the tx byte by state).

## Test plan
- Register-file model with r[i] = 32'h1000_0000+i, R15 = 32'h0000_0040, tx_ready = 1, pulse start. Required:
  - 81 bytes: A5, 50, 00, 00, 00, 10, 51, 01, 00, 00, 10, … 5F, 40, 00, 00, 00.
  - done at cycle 98.
  - busy high for cycles 1..97.
- Random tx_ready (~40% duty). Required:
  - Byte sequence identical to the first scenario.
  - tx_data stable and tx_valid never dropped while tx_valid && !tx_ready.
- FIRST_REG = 3, LAST_REG = 3, r3 = 32'hDEAD_BEEF. Required: A5, 53, EF, BE, AD, DE, then done.
- Overwrite r2 during reg 2's B1 stall. Required: the old r2 value completes. Then overwrite r5 before reg 5's LOAD. Required: the new r5 value is dumped.
- start pulses during busy and during the DONE cycle. Required: exactly one frame, no second dump.
- reset asserted at reg 7 B2. Required:
  - Next cycle tx_valid = 0, busy = 0, db_reg = 0, no done.
  - A subsequent start produces a full, correct frame.
